// File: rtl/backtrack_ctrl_pkg.sv
// Shared types for the DPLL backtrack controller and its assignment-stack neighbour.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 7
`endif

package backtrack_ctrl_pkg;

  localparam int VAR_BITS_DEF = `MAX_VARS_BITS;

  localparam logic TYPE_DECIDE = 1'b0;
  localparam logic TYPE_FORCED = 1'b1;

  typedef struct packed {
    logic                    etype;
    logic                    val;
    logic [VAR_BITS_DEF-1:0] var_idx;
  } stack_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FLIP = 2'd2,
    FAIL = 2'd3
  } bt_state_e;

endpackage

// File: rtl/backtrack_ctrl_if.sv
// Assignment-stack port bundle: master is the backtrack controller, slave is the stack.
interface backtrack_ctrl_if #(
  parameter int VAR_BITS = `MAX_VARS_BITS
);

  logic [VAR_BITS-1:0] stk_var_out;
  logic                stk_val_out;
  logic                stk_type_out;
  logic                stk_empty;
  logic                stk_full;
  logic                stk_push;
  logic                stk_pop;
  logic [VAR_BITS-1:0] stk_var_in;
  logic                stk_val_in;
  logic                stk_type_in;

  modport master (
    input  stk_var_out, stk_val_out, stk_type_out, stk_empty, stk_full,
    output stk_push, stk_pop, stk_var_in, stk_val_in, stk_type_in
  );

  modport slave (
    output stk_var_out, stk_val_out, stk_type_out, stk_empty, stk_full,
    input  stk_push, stk_pop, stk_var_in, stk_val_in, stk_type_in
  );

endinterface

// File: rtl/backtrack_ctrl.sv
// Conflict-driven backtrack: pops forced entries down to the latest decision, then
// re-pushes that decision negated as a forced entry; reports UNSAT if the stack drains.
module backtrack_ctrl
  import backtrack_ctrl_pkg::*;
#(
  parameter int VAR_BITS = `MAX_VARS_BITS,
  parameter int CNT_BITS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                conflict,
  backtrack_ctrl_if.master    stk,
  output logic                unassign_valid,
  output logic [VAR_BITS-1:0] unassign_var,
  output logic                assign_valid,
  output logic [VAR_BITS-1:0] assign_var,
  output logic                assign_val,
  output logic                busy,
  output logic                done,
  output logic                unsat,
  output logic [CNT_BITS-1:0] bt_count
);

  bt_state_e           state_q, state_d;
  logic [VAR_BITS-1:0] flip_var_q, flip_var_d;
  logic                flip_val_q, flip_val_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                push_s, pop_s, val_in_s, type_in_s;
  logic [VAR_BITS-1:0] var_in_s;

  always_comb begin
    state_d        = state_q;
    flip_var_d     = flip_var_q;
    flip_val_d     = flip_val_q;
    cnt_d          = cnt_q;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    var_in_s       = '0;
    val_in_s       = 1'b0;
    type_in_s      = 1'b0;
    unassign_valid = 1'b0;
    unassign_var   = '0;
    assign_valid   = 1'b0;
    assign_var     = '0;
    assign_val     = 1'b0;
    done           = 1'b0;
    unsat          = 1'b0;
    busy           = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (conflict) state_d = SCAN;
      end
      SCAN: begin
        if (stk.stk_empty) begin
          state_d = FAIL;
        end else begin
          pop_s          = 1'b1;
          unassign_valid = 1'b1;
          unassign_var   = stk.stk_var_out;
          if (stk.stk_type_out == TYPE_DECIDE) begin
            flip_var_d = stk.stk_var_out;
            flip_val_d = ~stk.stk_val_out;
            state_d    = FLIP;
          end
        end
      end
      FLIP: begin
        push_s       = 1'b1;
        var_in_s     = flip_var_q;
        val_in_s     = flip_val_q;
        type_in_s    = TYPE_FORCED;
        assign_valid = 1'b1;
        assign_var   = flip_var_q;
        assign_val   = flip_val_q;
        done         = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
        state_d      = IDLE;
      end
      FAIL: begin
        unsat   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The stack must not see a strobe while reset holds, even if reset lands mid-SCAN.
    if (reset) begin
      push_s         = 1'b0;
      pop_s          = 1'b0;
      var_in_s       = '0;
      val_in_s       = 1'b0;
      type_in_s      = 1'b0;
      unassign_valid = 1'b0;
      unassign_var   = '0;
      assign_valid   = 1'b0;
      assign_var     = '0;
      assign_val     = 1'b0;
      done           = 1'b0;
      unsat          = 1'b0;
      busy           = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      flip_var_q <= '0;
      flip_val_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      flip_var_q <= flip_var_d;
      flip_val_q <= flip_val_d;
      cnt_q      <= cnt_d;
    end
  end

  // A FLIP push always follows a pop, so a full stack here means the stack misbehaved.
  always_ff @(posedge clock) begin
    assert (reset || state_q != FLIP || !stk.stk_full)
      else $error("backtrack_ctrl: stack full while pushing flipped decision");
  end

  assign stk.stk_push    = push_s;
  assign stk.stk_pop     = pop_s;
  assign stk.stk_var_in  = var_in_s;
  assign stk.stk_val_in  = val_in_s;
  assign stk.stk_type_in = type_in_s;
  assign bt_count        = cnt_q;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Directed bench: behavioural assignment stack as neighbour, scoreboard of expected
// unassign/flip/unsat events checked by an independent monitor.
module tb_backtrack_ctrl;
  import backtrack_ctrl_pkg::*;

  localparam int VB = 7;
  localparam int CB = 32;
  localparam int DEPTH = 16;
  localparam logic [1:0] EV_NONE = 2'd0, EV_UNASSIGN = 2'd1, EV_FLIP = 2'd2, EV_UNSAT = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [VB-1:0] v;
    logic          val;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          conflict = 1'b0;
  logic          unassign_valid, assign_valid, assign_val, busy, done, unsat;
  logic [VB-1:0] unassign_var, assign_var;
  logic [CB-1:0] bt_count;

  int n_cmp = 0;
  int n_fail = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  backtrack_ctrl_if #(.VAR_BITS(VB)) sif ();

  backtrack_ctrl #(.VAR_BITS(VB), .CNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .conflict(conflict), .stk(sif.master),
    .unassign_valid(unassign_valid), .unassign_var(unassign_var),
    .assign_valid(assign_valid), .assign_var(assign_var), .assign_val(assign_val),
    .busy(busy), .done(done), .unsat(unsat), .bt_count(bt_count)
  );

  always #5 clock = ~clock;

  // Behavioural stack: top entry visible combinationally, push/pop land on posedge.
  stack_entry_t mem [DEPTH];
  stack_entry_t top_e, tb_ent;
  int           sp = 0;
  logic         stk_clr = 1'b0;
  logic         tb_push = 1'b0;

  assign top_e            = (sp > 0) ? mem[sp-1] : '0;
  assign sif.stk_var_out  = top_e.var_idx;
  assign sif.stk_val_out  = top_e.val;
  assign sif.stk_type_out = top_e.etype;
  assign sif.stk_empty    = (sp == 0);
  assign sif.stk_full     = (sp == DEPTH);

  always_ff @(posedge clock) begin
    if (stk_clr) begin
      sp <= 0;
    end else if (tb_push) begin
      mem[sp] <= tb_ent;
      sp      <= sp + 1;
    end else if (sif.stk_push) begin
      mem[sp] <= {sif.stk_type_in, sif.stk_val_in, sif.stk_var_in};
      sp      <= sp + 1;
    end else if (sif.stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic ev_t pop_exp();
    ev_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (sif.stk_push && sif.stk_pop) chk("push_pop_exclusive", 1, 0);
      if (unassign_valid || sif.stk_pop) begin
        mon_e = pop_exp();
        chk("unassign_kind", EV_UNASSIGN, mon_e.kind);
        chk("unassign_var", unassign_var, mon_e.v);
        chk("unassign_pop", {unassign_valid, sif.stk_pop}, 2'b11);
      end
      if (sif.stk_push || assign_valid || done) begin
        mon_e = pop_exp();
        chk("flip_kind", EV_FLIP, mon_e.kind);
        chk("flip_strobes", {sif.stk_push, assign_valid, done}, 3'b111);
        chk("flip_push_entry", {sif.stk_type_in, sif.stk_val_in, sif.stk_var_in},
            {TYPE_FORCED, mon_e.val, mon_e.v});
        chk("flip_assign", {assign_val, assign_var}, {mon_e.val, mon_e.v});
      end
      if (unsat) begin
        mon_e = pop_exp();
        chk("unsat_kind", EV_UNSAT, mon_e.kind);
        chk("unsat_quiet", {sif.stk_push, sif.stk_pop, done}, 3'b000);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic spush(input logic [VB-1:0] v, input logic val, input logic t);
    tb_ent  = '{etype: t, val: val, var_idx: v};
    tb_push = 1'b1;
    cyc(1);
    tb_push = 1'b0;
  endtask

  task automatic sclear();
    stk_clr = 1'b1;
    cyc(1);
    stk_clr = 1'b0;
  endtask

  task automatic exp_ev(input logic [1:0] k, input logic [VB-1:0] v, input logic val);
    exp_q.push_back('{kind: k, v: v, val: val});
  endtask

  task automatic run_conflict(input string nm, input int exp_lat, input bit hold);
    int lat;
    lat = 0;
    conflict = 1'b1;
    cyc(1);
    if (!hold) conflict = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done || unsat) begin
        lat = c;
        break;
      end
    end
    conflict = 1'b0;
    chk({nm, "_latency"}, lat, exp_lat);
    cyc(3);
  endtask

  function automatic logic [63:0] all_outs();
    return {sif.stk_push, sif.stk_pop, sif.stk_var_in, sif.stk_val_in, sif.stk_type_in,
            unassign_valid, unassign_var, assign_valid, assign_var, assign_val,
            busy, done, unsat};
  endfunction

  initial begin
    // T1: reset
    stk_clr = 1'b1;
    cyc(2);
    stk_clr = 1'b0;
    @(negedge clock);
    chk("t1_outs_in_reset", all_outs(), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t1_outs_after_reset", all_outs(), 0);
    chk("t1_bt_count", bt_count, 0);
    cyc(1);

    // T2: single decision
    spush(7'd12, 1'b0, TYPE_DECIDE);
    exp_ev(EV_UNASSIGN, 7'd12, 1'b0);
    exp_ev(EV_FLIP, 7'd12, 1'b1);
    run_conflict("t2", 2, 1'b0);
    chk("t2_bt_count", bt_count, 1);
    chk("t2_depth", sp, 1);
    chk("t2_top", mem[0], {TYPE_FORCED, 1'b1, 7'd12});

    // T5: repeat conflict, held high through the busy window
    exp_ev(EV_UNASSIGN, 7'd12, 1'b0);
    exp_ev(EV_UNSAT, 7'd0, 1'b0);
    run_conflict("t5", 3, 1'b1);
    cyc(4);
    chk("t5_bt_count", bt_count, 1);
    chk("t5_depth", sp, 0);
    chk("t5_idle", busy, 0);

    // T3: decision buried under forced entries
    spush(7'd14, 1'b1, TYPE_DECIDE);
    spush(7'd15, 1'b0, TYPE_FORCED);
    spush(7'd16, 1'b0, TYPE_FORCED);
    exp_ev(EV_UNASSIGN, 7'd16, 1'b0);
    exp_ev(EV_UNASSIGN, 7'd15, 1'b0);
    exp_ev(EV_UNASSIGN, 7'd14, 1'b0);
    exp_ev(EV_FLIP, 7'd14, 1'b0);
    run_conflict("t3", 4, 1'b0);
    chk("t3_bt_count", bt_count, 2);
    chk("t3_depth", sp, 1);
    chk("t3_top", mem[0], {TYPE_FORCED, 1'b0, 7'd14});

    // T4: only forced entries
    sclear();
    spush(7'd13, 1'b1, TYPE_FORCED);
    spush(7'd69, 1'b1, TYPE_FORCED);
    exp_ev(EV_UNASSIGN, 7'd69, 1'b0);
    exp_ev(EV_UNASSIGN, 7'd13, 1'b0);
    exp_ev(EV_UNSAT, 7'd0, 1'b0);
    run_conflict("t4", 4, 1'b0);
    chk("t4_bt_count", bt_count, 2);
    chk("t4_depth", sp, 0);

    // T6: reset lands right after the first pop
    sclear();
    spush(7'd20, 1'b0, TYPE_DECIDE);
    spush(7'd21, 1'b1, TYPE_FORCED);
    spush(7'd22, 1'b0, TYPE_FORCED);
    spush(7'd23, 1'b1, TYPE_FORCED);
    exp_ev(EV_UNASSIGN, 7'd23, 1'b0);
    conflict = 1'b1;
    cyc(1);
    conflict = 1'b0;
    cyc(1);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_no_strobe_in_reset", {sif.stk_push, sif.stk_pop}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_outs_after_reset", all_outs(), 0);
    chk("t6_bt_count", bt_count, 0);
    cyc(3);
    chk("t6_depth", sp, 3);
    chk("t6_top", mem[2], {TYPE_FORCED, 1'b0, 7'd22});
    chk("t6_idle", busy, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
